pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the CPU fetch stage. Extends the plain load/increment counter with four additions: relative branches, a hardware return-address stack for call/return, an interrupt entry vector and a stall input. All outputs are registered, and every control operation takes effect in one cycle. Stack misuse is reported through sticky error flags and never corrupts the PC.

---
 rtl/pc_seq_pkg.sv | 14 +
 rtl/pc_return_stack.sv | 62 ++++++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: operation encodings.
package pc_seq_pkg;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;
  localparam logic [2:0] OP_IRQ    = 3'b110;
  // 3'b111 is reserved and decodes as HOLD.
  localparam logic [2:0] OP_RSVD   = 3'b111;

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO. Push is dropped when full, pop is dropped when empty.
// The top entry is read combinationally from the registered depth so a pop
// sees its data in the same cycle.
module pc_return_stack #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic                               pop,
  input  logic [WIDTH-1:0]                   push_data,
  output logic [WIDTH-1:0]                   top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               full,
  output logic                               empty
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW = $clog2(STACK_DEPTH);

  logic [WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             do_push, do_pop;

  assign full    = (depth_q == DW'(STACK_DEPTH));
  assign empty   = (depth_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !do_push;
  assign wr_idx  = depth_q[AW-1:0];
  assign rd_idx  = wr_idx - AW'(1);
  assign top     = mem_q[rd_idx];
  assign depth   = depth_q;

  // Next-state depth: a push wins if both are requested.
  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + DW'(1);
    end else if (do_pop) begin
      depth_d = depth_q - DW'(1);
    end
  end

  // Depth register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Storage is not cleared on reset; only depth defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with relative branches, call/return through a
// hardware return stack, interrupt entry, stall and sticky stack-error flags.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     WIDTH        = 16,
  parameter int unsigned     STACK_DEPTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] IRQ_VECTOR   = WIDTH'(4)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic [2:0]                       op,
  input  logic [WIDTH-1:0]                 target,
  input  logic [WIDTH-1:0]                 offset,
  output logic [WIDTH-1:0]                 pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             empty,
  output logic                             full,
  output logic                             overflow,
  output logic                             underflow
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push, pop;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] stack_top;

  pc_return_stack #(
    .WIDTH      (WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_data(push_data),
    .top      (stack_top),
    .depth    (depth),
    .full     (full),
    .empty    (empty)
  );

  // Next-PC mux, stack requests and error flag updates for the current op.
  always_comb begin
    pc_d      = pc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_q + WIDTH'(1);
    if (!stall && !reset) begin
      case (op)
        OP_INC:    pc_d = pc_q + WIDTH'(1);
        OP_JUMP:   pc_d = target;
        OP_BRANCH: pc_d = pc_q + offset;
        OP_CALL: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = target;
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = stack_top;
          end
        end
        OP_IRQ: begin
          // Push the current pc so the interrupted instruction re-executes.
          push_data = pc_q;
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = IRQ_VECTOR;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  // PC and sticky flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc        = pc_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  op;
  logic [15:0] target;
  logic [15:0] offset;
  logic [15:0] pc;
  logic [3:0]  depth;
  logic        empty, full, overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(
    .WIDTH       (16),
    .STACK_DEPTH (8),
    .RESET_VECTOR(16'h0000),
    .IRQ_VECTOR  (16'h0004)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .op       (op),
    .target   (target),
    .offset   (offset),
    .pc       (pc),
    .depth    (depth),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one op across a single rising edge; returns at the following negedge.
  task automatic step(input logic [2:0] o, input logic [15:0] t, input logic [15:0] off,
                      input logic st);
    op     = o;
    target = t;
    offset = off;
    stall  = st;
    @(negedge clk);
  endtask

  logic [15:0] pushed [8];
  logic [15:0] prev_pc;

  initial begin
    reset  = 1'b1;
    stall  = 1'b0;
    op     = 3'b000;
    target = '0;
    offset = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_depth", depth, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    reset = 1'b0;

    // Increment, stall, reserved op.
    for (int i = 1; i <= 3; i++) begin
      step(3'b001, 16'h0, 16'h0, 1'b0);
      check("inc_pc", pc, i);
    end
    step(3'b001, 16'h0, 16'h0, 1'b1);
    check("stall_pc", pc, 3);
    check("stall_depth", depth, 0);
    step(3'b111, 16'h0, 16'h0, 1'b0);
    check("rsvd_pc", pc, 3);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    check("hold_pc", pc, 3);

    // Branch backwards and wrap.
    step(3'b010, 16'h0010, 16'h0, 1'b0);
    check("jump_pc", pc, 16'h0010);
    step(3'b011, 16'h0, 16'hFFFE, 1'b0);
    check("branch_pc", pc, 16'h000E);
    step(3'b010, 16'hFFFF, 16'h0, 1'b0);
    step(3'b001, 16'h0, 16'h0, 1'b0);
    check("wrap_pc", pc, 16'h0000);

    // Nested call/return.
    step(3'b010, 16'h0020, 16'h0, 1'b0);
    step(3'b100, 16'h0100, 16'h0, 1'b0);
    check("call1_pc", pc, 16'h0100);
    check("call1_depth", depth, 1);
    step(3'b100, 16'h0200, 16'h0, 1'b0);
    check("call2_pc", pc, 16'h0200);
    check("call2_depth", depth, 2);
    step(3'b101, 16'h0, 16'h0, 1'b0);
    check("ret1_pc", pc, 16'h0101);
    check("ret1_depth", depth, 1);
    step(3'b101, 16'h0, 16'h0, 1'b0);
    check("ret2_pc", pc, 16'h0021);
    check("ret2_depth", depth, 0);
    check("ret2_empty", empty, 1);

    // Fill the stack, overflow, then unwind in reverse order.
    step(3'b010, 16'h0000, 16'h0, 1'b0);
    prev_pc = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      pushed[i] = prev_pc + 16'h1;
      prev_pc   = 16'h1000 + 16'(i) * 16'h0100;
      step(3'b100, prev_pc, 16'h0, 1'b0);
      check("fill_pc", pc, prev_pc);
      check("fill_depth", depth, i + 1);
      check("fill_full", full, (i == 7) ? 1 : 0);
    end
    step(3'b100, 16'h9999, 16'h0, 1'b0);
    check("ovf_pc", pc, 16'h1700);
    check("ovf_flag", overflow, 1);
    check("ovf_depth", depth, 8);
    check("ovf_full", full, 1);
    step(3'b110, 16'h0, 16'h0, 1'b0);
    check("ovf_irq_pc", pc, 16'h1700);
    check("ovf_irq_depth", depth, 8);
    for (int k = 0; k < 8; k++) begin
      step(3'b101, 16'h0, 16'h0, 1'b0);
      check("unwind_pc", pc, pushed[7-k]);
      check("unwind_depth", depth, 7 - k);
    end
    check("unwind_empty", empty, 1);
    check("unwind_ovf_sticky", overflow, 1);

    // Underflow.
    step(3'b101, 16'h0, 16'h0, 1'b0);
    check("unf_pc", pc, 16'h0001);
    check("unf_flag", underflow, 1);
    check("unf_depth", depth, 0);
    step(3'b001, 16'h0, 16'h0, 1'b0);
    check("unf_inc_pc", pc, 16'h0002);
    check("unf_sticky", underflow, 1);

    // Interrupt entry and return.
    step(3'b010, 16'h0030, 16'h0, 1'b0);
    step(3'b110, 16'h0, 16'h0, 1'b0);
    check("irq_pc", pc, 16'h0004);
    check("irq_depth", depth, 1);
    step(3'b101, 16'h0, 16'h0, 1'b0);
    check("irq_ret_pc", pc, 16'h0030);
    check("irq_ret_depth", depth, 0);

    // Reset overrides a CALL and a stall in the same cycle.
    step(3'b100, 16'h0500, 16'h0, 1'b0);
    check("pre_rst_depth", depth, 1);
    reset = 1'b1;
    step(3'b100, 16'h0600, 16'h0, 1'b1);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_depth", depth, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_unf", underflow, 0);
    check("mid_rst_empty", empty, 1);
    reset = 1'b0;
    step(3'b001, 16'h0, 16'h0, 1'b0);
    check("post_rst_inc", pc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
